axicb_wr_arbiter: RTL and testbench

Write-path arbiter for one slave port of the crossbar. It shares the slave's AW channel between REQ_NB masters using round-robin.
- Each granted master index is logged in an in-order FIFO.
- The W channel is then routed strictly in AW grant order until each burst's wlast.
- It drives the one-hot select lines of the AW and W datapath muxes; it carries no payload.

---
 rtl/axicb_warb_pkg.sv | 21 ++
 rtl/axicb_warb_fifo.sv | 62 ++++++
 rtl/axicb_wr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_axicb_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_warb_pkg.sv
// Shared types and helpers for the crossbar write-path arbiter.
// Optional feature macro used by the arbiter: AXICB_WARB_PRIO_EN.
package axicb_warb_pkg;

  localparam int PRIO_LAYERS = 32'sd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } aw_state_e;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n < 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/axicb_warb_fifo.sv
// In-order FIFO of granted master indices; the head selects the W route.
// Pointers carry one extra wrap bit to tell full from empty.
module axicb_warb_fifo
  import axicb_warb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = idx_w(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer advance on push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_i) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= {(AW+1){1'b0}};
      rptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= data_i;
      end
    end
  end

  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/axicb_wr_arbiter.sv
// Round-robin AW arbiter for one crossbar slave port; W follows AW grant order.
// Define AXICB_WARB_PRIO_EN to arbitrate per MST_PRIO priority layer.
module axicb_wr_arbiter
  import axicb_warb_pkg::*;
#(
  parameter int                  REQ_NB   = 4,
  parameter int                  OSTD_NB  = 4,
  parameter logic [2*REQ_NB-1:0] MST_PRIO = '0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [REQ_NB-1:0] mst_awvalid,
  output logic [REQ_NB-1:0] mst_awready,
  output logic              slv_awvalid,
  input  logic              slv_awready,
  output logic [REQ_NB-1:0] aw_sel,
  input  logic [REQ_NB-1:0] mst_wvalid,
  input  logic [REQ_NB-1:0] mst_wlast,
  output logic [REQ_NB-1:0] mst_wready,
  output logic              slv_wvalid,
  output logic              slv_wlast,
  input  logic              slv_wready,
  output logic [REQ_NB-1:0] w_sel,
  output logic              ostd_full
);

  localparam int                IW   = idx_w(REQ_NB);
  localparam logic [REQ_NB-1:0] ONES = {REQ_NB{1'b1}};
  localparam logic [REQ_NB-1:0] ONE  = {{(REQ_NB-1){1'b0}}, 1'b1};

  // Lowest requester at or above the mask; wrap to the lowest requester overall.
  function automatic logic [REQ_NB-1:0] rr_pick(input logic [REQ_NB-1:0] req,
                                                input logic [REQ_NB-1:0] mask);
    logic [REQ_NB-1:0] cand;
    cand = req & mask;
    if (cand == {REQ_NB{1'b0}}) begin
      cand = req;
    end else begin
      cand = cand;
    end
    return cand & (~cand + ONE);
  endfunction

  function automatic logic [REQ_NB-1:0] mask_above(input logic [IW-1:0] idx);
    if (idx == IW'(REQ_NB - 1)) begin
      return ONES;
    end else begin
      return ONES << (int'(idx) + 1);
    end
  endfunction

  function automatic logic [IW-1:0] oh2idx(input logic [REQ_NB-1:0] oh);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = 0; i < REQ_NB; i++) begin
      if (oh[i]) begin
        idx = IW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  aw_state_e         state_q;
  logic [REQ_NB-1:0] aw_sel_q;
  logic [REQ_NB-1:0] grant_s;
  logic [IW-1:0]     sel_idx_s;
  logic [IW-1:0]     fifo_head_s;
  logic              fifo_empty_s;
  logic              aw_hs_s;
  logic              w_pop_s;

`ifdef AXICB_WARB_PRIO_EN
  logic [REQ_NB-1:0] mask_q      [PRIO_LAYERS];
  logic [REQ_NB-1:0] layer_req_s [PRIO_LAYERS];
  logic [1:0]        layer_q;
  logic [1:0]        win_layer_s;

  // Split requests by priority; only the highest populated layer competes.
  always_comb begin
    win_layer_s = 2'd0;
    for (int l = 0; l < PRIO_LAYERS; l++) begin
      layer_req_s[l] = {REQ_NB{1'b0}};
      for (int m = 0; m < REQ_NB; m++) begin
        layer_req_s[l][m] = mst_awvalid[m] & (MST_PRIO[2*m +: 2] == 2'(l));
      end
      if (|layer_req_s[l]) begin
        win_layer_s = 2'(l);
      end else begin
        win_layer_s = win_layer_s;
      end
    end
    grant_s = rr_pick(layer_req_s[win_layer_s], mask_q[win_layer_s]);
  end
`else
  logic [REQ_NB-1:0] mask_q;
  logic              unused_prio_s;

  assign unused_prio_s = ^MST_PRIO;

  // Flat round-robin over all requesters.
  always_comb begin
    grant_s = rr_pick(mst_awvalid, mask_q);
  end
`endif

  assign sel_idx_s = oh2idx(aw_sel_q);

  // AW grant FSM; the mask only moves on a completed handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      aw_sel_q <= {REQ_NB{1'b0}};
`ifdef AXICB_WARB_PRIO_EN
      layer_q  <= 2'd0;
      for (int l = 0; l < PRIO_LAYERS; l++) begin
        mask_q[l] <= ONES;
      end
`else
      mask_q   <= ONES;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((|mst_awvalid) && !ostd_full) begin
            aw_sel_q <= grant_s;
            state_q  <= ST_GRANT;
`ifdef AXICB_WARB_PRIO_EN
            layer_q  <= win_layer_s;
`endif
          end else begin
            aw_sel_q <= {REQ_NB{1'b0}};
            state_q  <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (aw_hs_s) begin
`ifdef AXICB_WARB_PRIO_EN
            mask_q[layer_q] <= mask_above(sel_idx_s);
`else
            mask_q <= mask_above(sel_idx_s);
`endif
            aw_sel_q <= {REQ_NB{1'b0}};
            state_q  <= ST_IDLE;
          end else if (!slv_awvalid) begin
            aw_sel_q <= {REQ_NB{1'b0}};
            state_q  <= ST_IDLE;
          end else begin
            aw_sel_q <= aw_sel_q;
            state_q  <= ST_GRANT;
          end
        end
        default: begin
          aw_sel_q <= {REQ_NB{1'b0}};
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake qualifiers are forced low while reset is sampled so nothing completes.
  assign aw_sel      = aw_sel_q;
  assign slv_awvalid = aresetn & (state_q == ST_GRANT) & (|(aw_sel_q & mst_awvalid));
  assign mst_awready = aw_sel_q & {REQ_NB{slv_awready & aresetn}};
  assign aw_hs_s     = slv_awvalid & slv_awready;

  axicb_warb_fifo #(
    .DEPTH (OSTD_NB),
    .WIDTH (IW)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .push_i  (aw_hs_s),
    .data_i  (sel_idx_s),
    .pop_i   (w_pop_s),
    .head_o  (fifo_head_s),
    .full_o  (ostd_full),
    .empty_o (fifo_empty_s)
  );

  assign w_sel      = fifo_empty_s ? {REQ_NB{1'b0}} : (ONE << fifo_head_s);
  assign slv_wvalid = aresetn & (|(w_sel & mst_wvalid));
  assign slv_wlast  = aresetn & (|(w_sel & mst_wlast));
  assign mst_wready = w_sel & {REQ_NB{slv_wready & aresetn}};
  assign w_pop_s    = slv_wvalid & slv_wready & slv_wlast;

endmodule

// File: tb/tb_axicb_wr_arbiter.sv
// Bench for axicb_wr_arbiter: vector table, directed corner sequences and a
// randomized run, all checked cycle by cycle against a queue-based model.
module tb_axicb_wr_arbiter;

  localparam int N    = 4;
  localparam int OSTD = 4;
`ifdef AXICB_WARB_PRIO_EN
  localparam logic [7:0] TB_PRIO = 8'b00_10_00_00;
`else
  localparam logic [7:0] TB_PRIO = 8'b00_00_00_00;
`endif

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [N-1:0] mst_awvalid, mst_awready, aw_sel;
  logic         slv_awvalid, slv_awready;
  logic [N-1:0] mst_wvalid, mst_wlast, mst_wready, w_sel;
  logic         slv_wvalid, slv_wlast, slv_wready, ostd_full;

  axicb_wr_arbiter #(.REQ_NB(N), .OSTD_NB(OSTD), .MST_PRIO(TB_PRIO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .mst_awvalid(mst_awvalid), .mst_awready(mst_awready),
    .slv_awvalid(slv_awvalid), .slv_awready(slv_awready), .aw_sel(aw_sel),
    .mst_wvalid(mst_wvalid), .mst_wlast(mst_wlast), .mst_wready(mst_wready),
    .slv_wvalid(slv_wvalid), .slv_wlast(slv_wlast), .slv_wready(slv_wready),
    .w_sel(w_sel), .ostd_full(ostd_full)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: order queue, pending grant, per-layer last-granted index.
  int q[$];
  int pend = -1;
  int pend_layer = 0;
  int last[4] = '{3, 3, 3, 3};

  // Samples of the DUT outputs from the most recent tick.
  logic [N-1:0] s_aw_sel, s_awready, s_w_sel, s_wready;
  logic         s_slv_awvalid, s_slv_wvalid, s_slv_wlast, s_full, s_aw_hs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int prio(input int m);
    return int'(TB_PRIO[2*m +: 2]);
  endfunction

  // Highest populated priority layer, then first requester after that layer's last grant.
  function automatic int pick(input logic [N-1:0] r, output int lay);
    int top = -1;
    int m;
    for (int i = 0; i < N; i++) if (r[i] && prio(i) > top) top = prio(i);
    lay = top;
    for (int k = 1; k <= N; k++) begin
      m = (last[top] + k) % N;
      if (r[m] && prio(m) == top) return m;
    end
    return -1;
  endfunction

  // Compare all outputs against the model, then advance the model across the edge.
  task automatic tick();
    logic [19:0] act, exp;
    logic [3:0]  e_aw, e_awr, e_w, e_wr;
    logic        e_awv, e_wv, e_wl, e_full;
    int          hd, np;
    bit          push, pop;
    #1;
    hd     = (q.size() > 0) ? q[0] : -1;
    e_aw   = (pend >= 0) ? 4'(1 << pend) : 4'd0;
    e_awv  = (pend >= 0) ? (aresetn & mst_awvalid[pend]) : 1'b0;
    e_awr  = (pend >= 0 && aresetn && slv_awready) ? e_aw : 4'd0;
    e_w    = (hd >= 0) ? 4'(1 << hd) : 4'd0;
    e_wv   = (hd >= 0) ? (aresetn & mst_wvalid[hd]) : 1'b0;
    e_wl   = (hd >= 0) ? (aresetn & mst_wlast[hd]) : 1'b0;
    e_wr   = (hd >= 0 && aresetn && slv_wready) ? e_w : 4'd0;
    e_full = (q.size() == OSTD);
    exp = {e_aw, e_awr, e_awv, e_w, e_wr, e_wv, e_wl, e_full};
    act = {aw_sel, mst_awready, slv_awvalid, w_sel, mst_wready, slv_wvalid, slv_wlast, ostd_full};
    chk("cycle", 32'(act), 32'(exp));
    s_aw_sel = aw_sel; s_awready = mst_awready; s_w_sel = w_sel; s_wready = mst_wready;
    s_slv_awvalid = slv_awvalid; s_slv_wvalid = slv_wvalid; s_slv_wlast = slv_wlast;
    s_full = ostd_full; s_aw_hs = slv_awvalid & slv_awready;
    if (!aresetn) begin
      pend = -1;
      q.delete();
      for (int l = 0; l < 4; l++) last[l] = N - 1;
    end else begin
      push = e_awv && slv_awready;
      pop  = e_wv && slv_wready && e_wl;
      np   = pend;
      if (pend >= 0) begin
        if (push) begin
          last[pend_layer] = pend;
          pend = -1;
        end else if (!mst_awvalid[pend]) begin
          pend = -1;
        end
      end else if (mst_awvalid != 4'd0 && !e_full) begin
        pend = pick(mst_awvalid, pend_layer);
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(np);
    end
    @(negedge aclk);
  endtask

  // Simple master agents: AW pending flags and remaining W beats per master.
  logic [N-1:0] awp;
  int           wb[N];
  bit           early;

  task automatic mstep(input logic awr_v, input logic wr_v);
    for (int m = 0; m < N; m++) begin
      mst_awvalid[m] = awp[m];
      mst_wvalid[m]  = (wb[m] > 0);
      mst_wlast[m]   = (wb[m] == 1);
    end
    slv_awready = awr_v;
    slv_wready  = wr_v;
    tick();
    for (int m = 0; m < N; m++) begin
      if (awp[m] && s_awready[m]) awp[m] = 1'b0;
      if (wb[m] > 0 && s_wready[m]) begin
        if (m == 2 && wb[0] > 0) early = 1'b1;
        if (m == 2 && wb[2] == 1) chk("t4 wlast on 3rd beat", 32'(s_slv_wlast), 32'd1);
        wb[m]--;
      end
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    awp = 4'd0;
    for (int m = 0; m < N; m++) wb[m] = 0;
    mstep(1'b0, 1'b0);
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic       rstn;
    logic [3:0] awv;
    logic [3:0] e_aw;
    logic [3:0] e_w;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] a, input logic [3:0] ea,
                              input logic [3:0] ew);
    vec_t v;
    v.rstn = r; v.awv = a; v.e_aw = ea; v.e_w = ew;
    return v;
  endfunction

  int n_hs;
  int grants[$];

  initial begin
    // Full rotation with single-beat bursts, a reset, then requests 1101.
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0001, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0001));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0010, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0010));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0100, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0100));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1000, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b1000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0001, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0001));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b0000, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b0001, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b0000, 4'b0001));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b0100, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b0000, 4'b0100));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1000, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b0000, 4'b1000));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b0001, 4'b0000));

    aresetn = 1'b0;
    mst_awvalid = 4'd0; mst_wvalid = 4'd0; mst_wlast = 4'd0;
    slv_awready = 1'b0; slv_wready = 1'b0;
    awp = 4'd0;
    early = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    tick();

`ifndef AXICB_WARB_PRIO_EN
    for (int i = 0; i < tbl.size(); i++) begin
      aresetn = tbl[i].rstn;
      mst_awvalid = tbl[i].awv;
      mst_wvalid = 4'b1111; mst_wlast = 4'b1111;
      slv_awready = 1'b1; slv_wready = 1'b1;
      tick();
      chk($sformatf("tbl[%0d] aw_sel,w_sel", i), 32'({s_aw_sel, s_w_sel}),
          32'({tbl[i].e_aw, tbl[i].e_w}));
    end
`endif

    // Outstanding limit: W stalled, AW grants stop at OSTD, one wlast frees one slot.
    do_reset();
    mst_awvalid = 4'b1111; mst_wvalid = 4'b1111; mst_wlast = 4'b1111;
    slv_awready = 1'b1; slv_wready = 1'b0;
    n_hs = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_aw_hs) n_hs++;
    end
    chk("t3 aw handshakes to full", 32'(n_hs), 32'd4);
    chk("t3 ostd_full", 32'(s_full), 32'd1);
    chk("t3 slv_awvalid held low", 32'(s_slv_awvalid), 32'd0);
    slv_wready = 1'b1;
    tick();
    slv_wready = 1'b0;
    n_hs = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_aw_hs) n_hs++;
    end
    chk("t3 aw handshakes after pop", 32'(n_hs), 32'd1);

    // W before AW from a master not at the FIFO head is held back.
    do_reset();
    awp = 4'b0101; wb[0] = 2; wb[2] = 3; early = 1'b0;
    for (int c = 0; c < 30 && (wb[0] + wb[2]) > 0; c++) mstep(1'b1, 1'b1);
    chk("t4 m2 wready before m0 wlast", 32'(early), 32'd0);
    chk("t4 beats left", 32'(wb[0] + wb[2]), 32'd0);

    // Reset in GRANT with a 4-beat burst half done.
    do_reset();
    awp = 4'b0011; wb[0] = 4;
    repeat (3) mstep(1'b1, 1'b1);
    mstep(1'b0, 1'b1);
    chk("t5 beats before reset", 32'(wb[0]), 32'd2);
    aresetn = 1'b0;
    mstep(1'b1, 1'b1);
    aresetn = 1'b1;
    awp = 4'b1111;
    for (int m = 0; m < N; m++) wb[m] = 0;
    mstep(1'b0, 1'b1);
    chk("t5 outputs zero after reset",
        32'({s_aw_sel, s_awready, s_slv_awvalid, s_w_sel, s_wready, s_slv_wvalid, s_slv_wlast, s_full}),
        32'd0);
    mstep(1'b0, 1'b1);
    chk("t5 first grant", 32'(s_aw_sel), 32'b0001);

`ifdef AXICB_WARB_PRIO_EN
    do_reset();
    mst_wvalid = 4'b1111; mst_wlast = 4'b1111;
    slv_awready = 1'b1; slv_wready = 1'b1;
    mst_awvalid = 4'b1111;
    n_hs = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_aw_hs) begin
        n_hs++;
        chk("t6 high prio grant", 32'(s_aw_sel), 32'b0100);
      end
    end
    chk("t6 high prio handshakes", 32'(n_hs), 32'd5);
    mst_awvalid = 4'b1011;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_aw_hs) for (int m = 0; m < N; m++) if (s_aw_sel[m]) grants.push_back(m);
    end
    chk("t6 grant count", 32'(grants.size() >= 3), 32'd1);
    if (grants.size() >= 3) begin
      chk("t6 grant 0", 32'(grants[0]), 32'd0);
      chk("t6 grant 1", 32'(grants[1]), 32'd1);
      chk("t6 grant 2", 32'(grants[2]), 32'd3);
    end
`endif

    // Randomized traffic, including occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      aresetn     = ($urandom_range(0, 99) != 0);
      mst_awvalid = 4'($urandom_range(0, 15));
      mst_wvalid  = 4'($urandom_range(0, 15));
      mst_wlast   = 4'($urandom_range(0, 15));
      slv_awready = ($urandom_range(0, 3) != 0);
      slv_wready  = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
